soc_ctrl_tmr_scrubber: RTL and testbench
========================================

Name: soc_ctrl_tmr_scrubber

Overview:
- Background scrub controller for the triplicated SoC control register file.
- Periodically sweeps all protected registers and reads the three replica values of each.
- Bitwise-majority-votes the values and writes the voted value back into any disagreeing replica.
- Yields to software bus accesses, keeps saturating per-replica fault counters, and flags multi-replica corruption.

Parameters:
- NumRegs, 5, number of protected registers swept per pass (IdxW = max(1, $clog2(NumRegs))).
- DataWidth, 32, width of each register value (narrower registers zero-extended outside).
- ScrubPeriod, 1024, idle cycles between sweeps (must be >= 1).
- CntWidth, 8, width of each per-replica fault counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  scrubbing enabled; sampled only in IDLE.
- bus_busy_i  in  1  software APB access in flight on the register file; scrubber must not sample or write.
- reg_sel_o  out  IdxW  index of the register currently being scrubbed.
- rep_a_i / rep_b_i / rep_c_i  in  DataWidth each  replica 0/1/2 value of register reg_sel_o (combinational mux outside).
- fix_we_o  out  3  per-replica write enable; bit i writes fix_data_o into replica i.
- fix_data_o  out  DataWidth  voted correction value.
- fault_clr_i  in  1  clears fault counters and multi_fault_o.
- fault_cnt_o  out  3*CntWidth  saturating correction counts; replica i in bits [i*CntWidth +: CntWidth].
- multi_fault_o  out  1  sticky; set when all three replicas pairwise differ.
- busy_o  out  1  high while a sweep is in progress (any state except IDLE).
- sweep_done_o  out  1  one-cycle pulse at the end of every completed sweep.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timer = ScrubPeriod-1; idx = 0; captured values and maj_q = 0.
- IDLE:
  - enable_i=0: timer reloads to ScrubPeriod-1.
  - enable_i=1: timer decrements; at timer==0, next state is SAMPLE, idx=0.
- SAMPLE:
  - reg_sel_o = idx.
  - bus_busy_i=1: stay in SAMPLE, no capture.
  - Otherwise: capture rep_a/b/c into a_q/b_q/c_q at the clock edge; next state is CHECK.
- CHECK:
  - maj = (a&b)|(a&c)|(b&c); register maj_q <= maj.
  - mask[i] = (replica_i_q != maj).
  - If a_q!=b_q, b_q!=c_q and a_q!=c_q: set multi_fault_o.
  - mask==0: next state is ADVANCE; otherwise next state is FIX.
- FIX:
  - bus_busy_i=1: no write; next state is SAMPLE (same idx, re-read, since software may have changed the value).
  - Otherwise: fix_we_o = mask for exactly this one cycle; fix_data_o = maj_q; each masked counter increments, saturating at 2^CntWidth-1; next state is ADVANCE.
- ADVANCE:
  - idx==NumRegs-1: sweep_done_o=1 for this cycle, idx=0, timer reloads, next state is IDLE.
  - Otherwise: idx++, next state is SAMPLE.
- Latency:
  - Clean register: 3 cycles (SAMPLE, CHECK, ADVANCE).
  - Corrected register: 4 cycles.
  - Clean sweep with NumRegs=5: 15 cycles from leaving IDLE to the sweep_done_o pulse.
- fix_we_o is never asserted while bus_busy_i=1. It is asserted only in FIX, for one cycle per correction.
- fix_data_o holds maj_q at all times (registered output); it is only meaningful when fix_we_o != 0.
- enable_i deasserted mid-sweep: the current sweep completes; the scrubber then stays in IDLE.
- fault_clr_i:
  - Zeroes all counters and multi_fault_o next cycle.
  - On the same cycle as an increment or a multi_fault set, clear wins and the event is dropped.
- Counters do not wrap.
- reg_sel_o holds its last value in IDLE (reset value 0).
- Reset asserted mid-sweep: immediate return to reset state; any pending fix is abandoned with no write.

Test Plan:
1. ScrubPeriod=16, enable_i=1, all replicas equal per register -> first busy_o 16 cycles after reset release; sweep_done_o pulses 15 cycles later; fix_we_o stays 0; counters stay 0.
2. Register 2: rep_b=0x0000_00FF while rep_a=rep_c=0x1000_0000 -> in FIX cycle reg_sel_o=2, fix_we_o=3'b010, fix_data_o=0x1000_0000; fault_cnt[1]=1.
3. Register 0: a=0x1, b=0x2, c=0x4 -> multi_fault_o=1; fix_data_o=0x0; fix_we_o=3'b111; all three counters = 1.
4. bus_busy_i held high on entering FIX for 3 cycles, with the replica corrected by software meanwhile -> no fix_we_o pulse; FSM re-enters SAMPLE, finds agreement, advances; counters unchanged.
5. CntWidth=2, same replica fault injected over 5 sweeps -> counter reads 1,2,3,3,3; fault_clr_i asserted on a FIX cycle -> counter 0, increment dropped.
6. Reset asserted during CHECK with a pending mismatch -> all outputs 0 next cycle; no fix_we_o; after release, timer restarts the full ScrubPeriod.

Source files
------------

// File: rtl/soc_ctrl_tmr_scrubber.sv
// Background scrubber for the triplicated SoC control register file.
// It periodically sweeps every protected register and bitwise-majority-votes
// the three replicas. It writes the voted value back into any replica that
// disagrees, backing off whenever software owns the register-file bus.
module soc_ctrl_tmr_scrubber #(
    parameter int unsigned NumRegs     = 5,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ScrubPeriod = 1024,
    parameter int unsigned CntWidth    = 8,
    localparam int unsigned IdxW       = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    bus_busy_i,
    output logic [IdxW-1:0]         reg_sel_o,
    input  logic [DataWidth-1:0]    rep_a_i,
    input  logic [DataWidth-1:0]    rep_b_i,
    input  logic [DataWidth-1:0]    rep_c_i,
    output logic [2:0]              fix_we_o,
    output logic [DataWidth-1:0]    fix_data_o,
    input  logic                    fault_clr_i,
    output logic [3*CntWidth-1:0]   fault_cnt_o,
    output logic                    multi_fault_o,
    output logic                    busy_o,
    output logic                    sweep_done_o
);

    localparam int unsigned TimerW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;
    localparam logic [TimerW-1:0] TimerReload = TimerW'(ScrubPeriod - 1);
    localparam logic [IdxW-1:0]   LastIdx     = IdxW'(NumRegs - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_FIX,
        ST_ADVANCE
    } state_e;

    state_e                          state_q, state_d;
    logic [TimerW-1:0]               timer_q, timer_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [DataWidth-1:0]            a_q, a_d;
    logic [DataWidth-1:0]            b_q, b_d;
    logic [DataWidth-1:0]            c_q, c_d;
    logic [DataWidth-1:0]            maj_q, maj_d;
    logic [2:0][CntWidth-1:0]        cnt_q, cnt_d;
    logic                            multi_q, multi_d;

    logic [DataWidth-1:0]            maj_c;
    logic [2:0]                      chk_mask_c;
    logic [2:0]                      fix_mask_c;
    logic                            all_differ_c;

    // Bitwise vote over the captured replicas plus disagreement masks.
    // The CHECK decision uses the live vote; the FIX write uses the registered one.
    always_comb begin
        maj_c        = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
        chk_mask_c   = {c_q != maj_c, b_q != maj_c, a_q != maj_c};
        fix_mask_c   = {c_q != maj_q, b_q != maj_q, a_q != maj_q};
        all_differ_c = (a_q != b_q) && (b_q != c_q) && (a_q != c_q);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= TimerReload;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            maj_q   <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            maj_q   <= maj_d;
            cnt_q   <= cnt_d;
            multi_q <= multi_d;
        end
    end

    // Next-state logic: period timer, sweep sequencing, capture, vote and fault bookkeeping.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        maj_d   = maj_q;
        cnt_d   = cnt_q;
        multi_d = multi_q;

        case (state_q)
            ST_IDLE: begin
                if (!enable_i) begin
                    timer_d = TimerReload;
                end else if (timer_q == '0) begin
                    state_d = ST_SAMPLE;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            ST_SAMPLE: begin
                if (!bus_busy_i) begin
                    a_d     = rep_a_i;
                    b_d     = rep_b_i;
                    c_d     = rep_c_i;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                maj_d = maj_c;
                if (all_differ_c) begin
                    multi_d = 1'b1;
                end
                state_d = (chk_mask_c == 3'b000) ? ST_ADVANCE : ST_FIX;
            end
            ST_FIX: begin
                // Software may have rewritten the register meanwhile, so re-read it.
                if (bus_busy_i) begin
                    state_d = ST_SAMPLE;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (fix_mask_c[i] && (cnt_q[i] != '1)) begin
                            cnt_d[i] = cnt_q[i] + CntWidth'(1);
                        end
                    end
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    timer_d = TimerReload;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = ST_SAMPLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing takes priority over any same-cycle increment or multi-fault set.
        if (fault_clr_i) begin
            cnt_d   = '0;
            multi_d = 1'b0;
        end
    end

    // Outputs decoded from registers; the write strobe is additionally gated by the live bus-busy.
    always_comb begin
        reg_sel_o     = idx_q;
        fix_data_o    = maj_q;
        fault_cnt_o   = cnt_q;
        multi_fault_o = multi_q;
        busy_o        = (state_q != ST_IDLE);
        sweep_done_o  = (state_q == ST_ADVANCE) && (idx_q == LastIdx);
        fix_we_o      = ((state_q == ST_FIX) && !bus_busy_i) ? fix_mask_c : 3'b000;
    end

endmodule

// File: tb/tb_soc_ctrl_tmr_scrubber.sv
// Directed bench for soc_ctrl_tmr_scrubber: the bench itself holds the replica
// register file and injects faults; expected values are worked out by hand.
module tb_soc_ctrl_tmr_scrubber;

    localparam int unsigned NumRegs     = 5;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned ScrubPeriod = 16;
    localparam int unsigned CntWidth    = 2;
    localparam int unsigned IdxW        = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   enable_i;
    logic                   bus_busy_i;
    logic [IdxW-1:0]        reg_sel_o;
    logic [DataWidth-1:0]   rep_a_i, rep_b_i, rep_c_i;
    logic [2:0]             fix_we_o;
    logic [DataWidth-1:0]   fix_data_o;
    logic                   fault_clr_i;
    logic [3*CntWidth-1:0]  fault_cnt_o;
    logic                   multi_fault_o;
    logic                   busy_o;
    logic                   sweep_done_o;

    logic [DataWidth-1:0]   rf_a [NumRegs];
    logic [DataWidth-1:0]   rf_b [NumRegs];
    logic [DataWidth-1:0]   rf_c [NumRegs];

    int errors = 0;
    int checks = 0;

    // Sweep observation results.
    int                     sw_nfix;
    int                     sw_len;
    logic                   sw_done;
    logic [2:0]             sw_we;
    logic [DataWidth-1:0]   sw_data;
    logic [IdxW-1:0]        sw_sel;

    soc_ctrl_tmr_scrubber #(
        .NumRegs     (NumRegs),
        .DataWidth   (DataWidth),
        .ScrubPeriod (ScrubPeriod),
        .CntWidth    (CntWidth)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .bus_busy_i    (bus_busy_i),
        .reg_sel_o     (reg_sel_o),
        .rep_a_i       (rep_a_i),
        .rep_b_i       (rep_b_i),
        .rep_c_i       (rep_c_i),
        .fix_we_o      (fix_we_o),
        .fix_data_o    (fix_data_o),
        .fault_clr_i   (fault_clr_i),
        .fault_cnt_o   (fault_cnt_o),
        .multi_fault_o (multi_fault_o),
        .busy_o        (busy_o),
        .sweep_done_o  (sweep_done_o)
    );

    always #5 clk_i = ~clk_i;

    // External replica mux selected by the scrubber.
    assign rep_a_i = (int'(reg_sel_o) < NumRegs) ? rf_a[reg_sel_o] : '0;
    assign rep_b_i = (int'(reg_sel_o) < NumRegs) ? rf_b[reg_sel_o] : '0;
    assign rep_c_i = (int'(reg_sel_o) < NumRegs) ? rf_c[reg_sel_o] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge; outputs are stable there.
    task automatic cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_busy(input string tag, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            if (busy_o) begin
                seen = 1'b1;
                n    = k;
                break;
            end
        end
        check({tag, "_busy_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic run_sweep(input string tag);
        sw_nfix = 0;
        sw_len  = int'(busy_o);
        sw_done = 1'b0;
        sw_we   = '0;
        sw_data = '0;
        sw_sel  = '0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (busy_o) sw_len++;
            if (fix_we_o != 3'b000) begin
                sw_nfix++;
                sw_we   = fix_we_o;
                sw_data = fix_data_o;
                sw_sel  = reg_sel_o;
            end
            if (sweep_done_o) begin
                sw_done = 1'b1;
                break;
            end
        end
        check({tag, "_sweep_done"}, 64'(sw_done), 64'd1);
    endtask

    task automatic do_clear();
        fault_clr_i = 1'b1;
        cycle();
        fault_clr_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy_o),        64'd0);
        check({tag, "_sel"},   64'(reg_sel_o),     64'd0);
        check({tag, "_we"},    64'(fix_we_o),      64'd0);
        check({tag, "_data"},  64'(fix_data_o),    64'd0);
        check({tag, "_cnt"},   64'(fault_cnt_o),   64'd0);
        check({tag, "_multi"}, 64'(multi_fault_o), 64'd0);
        check({tag, "_done"},  64'(sweep_done_o),  64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   n;
        int   done_at;
        logic any_fix;
        logic any_busy;
        int   exp_sat [5];
        exp_sat = '{1, 2, 3, 3, 3};

        rst_i       = 1'b1;
        enable_i    = 1'b0;
        bus_busy_i  = 1'b0;
        fault_clr_i = 1'b0;
        for (int r = 0; r < NumRegs; r++) begin
            rf_a[r] = 32'hA5A5_0000 + DataWidth'(r);
            rf_b[r] = 32'hA5A5_0000 + DataWidth'(r);
            rf_c[r] = 32'hA5A5_0000 + DataWidth'(r);
        end
        repeat (3) cycle();
        check_all_zero("reset");

        // Clean sweep: idle period then 15 cycles to the done pulse.
        enable_i = 1'b1;
        rst_i    = 1'b0;
        wait_busy("t1", n);
        check("t1_idle_cycles", 64'(n), 64'd16);
        run_sweep("t1");
        check("t1_sweep_len", 64'(sw_len), 64'd15);
        check("t1_nfix", 64'(sw_nfix), 64'd0);
        check("t1_cnt", 64'(fault_cnt_o), 64'd0);
        cycle();
        check("t1_idle_after", 64'(busy_o), 64'd0);

        // Single-replica fault on register 2, replica 1.
        rf_a[2] = 32'h1000_0000;
        rf_b[2] = 32'h0000_00FF;
        rf_c[2] = 32'h1000_0000;
        run_sweep("t2");
        check("t2_len", 64'(sw_len), 64'd16);
        check("t2_nfix", 64'(sw_nfix), 64'd1);
        check("t2_sel", 64'(sw_sel), 64'd2);
        check("t2_we", 64'(sw_we), 64'b010);
        check("t2_data", 64'(sw_data), 64'h1000_0000);
        check("t2_cnt", 64'(fault_cnt_o), 64'h04);
        check("t2_multi", 64'(multi_fault_o), 64'd0);
        rf_b[2] = 32'h1000_0000;
        do_clear();
        check("t2_clr_cnt", 64'(fault_cnt_o), 64'd0);

        // All three replicas pairwise differ on register 0.
        rf_a[0] = 32'h1;
        rf_b[0] = 32'h2;
        rf_c[0] = 32'h4;
        run_sweep("t3");
        check("t3_nfix", 64'(sw_nfix), 64'd1);
        check("t3_sel", 64'(sw_sel), 64'd0);
        check("t3_we", 64'(sw_we), 64'b111);
        check("t3_data", 64'(sw_data), 64'h0);
        check("t3_multi", 64'(multi_fault_o), 64'd1);
        check("t3_cnt", 64'(fault_cnt_o), 64'h15);
        rf_a[0] = 32'hA5A5_0000;
        rf_b[0] = 32'hA5A5_0000;
        rf_c[0] = 32'hA5A5_0000;
        do_clear();
        check("t3_clr_cnt", 64'(fault_cnt_o), 64'd0);
        check("t3_clr_multi", 64'(multi_fault_o), 64'd0);

        // Bus busy across the FIX of register 3 while software repairs the replica.
        rf_c[3] = 32'hDEAD_BEEF;
        wait_busy("t4", n);
        any_fix = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 25; i++) begin
            cycle();
            if (fix_we_o != 3'b000) any_fix = 1'b1;
            if (sweep_done_o && done_at < 0) done_at = i;
            if (i == 11) begin
                check("t4_fix_blocked", 64'(fix_we_o), 64'd0);
                check("t4_fix_sel", 64'(reg_sel_o), 64'd3);
                rf_c[3] = 32'hA5A5_0003;
            end
            if (i == 10) bus_busy_i = 1'b1;
            if (i == 13) bus_busy_i = 1'b0;
        end
        check("t4_no_write", 64'(any_fix), 64'd0);
        check("t4_done_at", 64'(done_at), 64'd18);
        check("t4_cnt", 64'(fault_cnt_o), 64'd0);

        // Persistent replica-0 fault on register 1: 2-bit counter saturates.
        rf_a[1] = 32'h0BAD_0001;
        for (int s = 0; s < 5; s++) begin
            run_sweep("t5");
            check($sformatf("t5_cnt_sweep%0d", s), 64'(fault_cnt_o), 64'(exp_sat[s]));
        end
        check("t5_we", 64'(sw_we), 64'b001);
        do_clear();
        check("t5_clr", 64'(fault_cnt_o), 64'd0);
        // Clear coincident with the FIX cycle drops that increment.
        wait_busy("t5c", n);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (i == 5) begin
                check("t5c_fix_we", 64'(fix_we_o), 64'b001);
                fault_clr_i = 1'b1;
            end
            if (i == 6) begin
                fault_clr_i = 1'b0;
                check("t5c_cnt_dropped", 64'(fault_cnt_o), 64'd0);
            end
        end
        run_sweep("t5d");
        run_sweep("t5e");
        check("t5e_cnt", 64'(fault_cnt_o), 64'd1);
        rf_a[1] = 32'hA5A5_0001;

        // Reset during CHECK with a pending mismatch on register 0.
        rf_b[0] = 32'h5555_5555;
        wait_busy("t6", n);
        cycle();
        rst_i = 1'b1;
        #1;
        check_all_zero("t6_rst");
        cycle();
        check("t6_rst_we", 64'(fix_we_o), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        wait_busy("t6r", n);
        check("t6_idle_cycles", 64'(n), 64'd16);
        run_sweep("t6s");
        check("t6_nfix", 64'(sw_nfix), 64'd1);
        check("t6_sel", 64'(sw_sel), 64'd0);
        check("t6_we", 64'(sw_we), 64'b010);
        check("t6_data", 64'(sw_data), 64'hA5A5_0000);
        check("t6_cnt", 64'(fault_cnt_o), 64'h04);
        rf_b[0] = 32'hA5A5_0000;

        // Enable dropped mid-sweep: the sweep completes, then the scrubber stays idle.
        wait_busy("t7", n);
        enable_i = 1'b0;
        run_sweep("t7");
        check("t7_len", 64'(sw_len), 64'd15);
        any_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (busy_o) any_busy = 1'b1;
        end
        check("t7_stays_idle", 64'(any_busy), 64'd0);
        check("t7_sel_held", 64'(reg_sel_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
